// File: rtl/pipelined_datapath.sv
// rtl/pipelined_datapath.sv - two-stage EX/WB integer datapath with forwarding and load stall
module pipelined_datapath #(
    parameter int WIDTH        = 32,
    parameter int ADRX_W       = 5,
    parameter int IMM_W        = 16,
    parameter int MEM_W        = 16,
    parameter int SIGN_EXT_IMM = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inValid,
    output logic              inReady,
    input  logic [IMM_W-1:0]  immediate,
    input  logic [ADRX_W-1:0] rfRdAdrx0,
    input  logic [ADRX_W-1:0] rfRdAdrx1,
    input  logic [ADRX_W-1:0] rfWrAdrx,
    input  logic [2:0]        aluCtl,
    input  logic              rfWriteEn,
    input  logic              aluBusBSel,
    input  logic              dmemResultSel,
    input  logic              regDest,
    input  logic              flagWriteEn,
    input  logic [MEM_W-1:0]  dmemOutput,
    input  logic              dmemReady,
    output logic              dmemReq,
    output logic [WIDTH-1:0]  dmemAdrx,
    output logic [MEM_W-1:0]  dmemDataIn,
    output logic              cFlag,
    output logic              nFlag,
    output logic              vFlag,
    output logic              zFlag,
    output logic              wbValid
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int DEPTH = 1 << ADRX_W;

    typedef enum logic [1:0] {IDLE, ALU_WB, LOAD_WAIT} wb_state_t;

    wb_state_t         state, state_next;
    logic [WIDTH-1:0]  rf [DEPTH];
    logic [ADRX_W-1:0] wb_dst;
    logic              wb_we;

    logic              accept;
    logic              wb_free;
    logic              rf_we;
    logic [WIDTH-1:0]  rf_wdata;
    logic [WIDTH-1:0]  load_ext;
    logic [WIDTH-1:0]  imm_ext;
    logic [WIDTH-1:0]  reg_a, reg_b, op_b;
    logic [WIDTH-1:0]  alu_res;
    logic [WIDTH:0]    sum;
    logic              alu_c, alu_v;

    // WB can take a new instruction unless a load is still waiting on memory
    assign wb_free  = (state != LOAD_WAIT) || dmemReady;
    assign inReady  = wb_free;
    assign accept   = inValid && inReady;
    assign dmemReq  = (state == LOAD_WAIT);

    assign load_ext = WIDTH'($signed(dmemOutput));
    assign imm_ext  = (SIGN_EXT_IMM != 0) ? WIDTH'($signed(immediate)) : WIDTH'(immediate);

    // Register-file write happens on the cycle the WB instruction retires
    assign rf_we    = wb_we && ((state == ALU_WB) || ((state == LOAD_WAIT) && dmemReady));
    assign rf_wdata = (state == LOAD_WAIT) ? load_ext : dmemAdrx;

    // Retiring value bypasses the array; this is both forwarding and write-first reads
    assign reg_a = (rf_we && (wb_dst == rfRdAdrx0)) ? rf_wdata : rf[rfRdAdrx0];
    assign reg_b = (rf_we && (wb_dst == rfRdAdrx1)) ? rf_wdata : rf[rfRdAdrx1];
    assign op_b  = aluBusBSel ? imm_ext : reg_b;

    // ALU with carry/overflow only meaningful for add and subtract
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sum     = '0;
        case (aluCtl)
            3'b000: begin
                sum     = {1'b0, reg_a} + {1'b0, op_b};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (reg_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != reg_a[WIDTH-1]);
            end
            3'b001: begin
                sum     = {1'b0, reg_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (reg_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != reg_a[WIDTH-1]);
            end
            3'b010:  alu_res = reg_a & op_b;
            3'b011:  alu_res = reg_a | op_b;
            3'b100:  alu_res = reg_a ^ op_b;
            3'b101:  alu_res = WIDTH'($signed(reg_a) < $signed(op_b));
            3'b110:  alu_res = reg_a << op_b[SH_W-1:0];
            default: alu_res = op_b;
        endcase
    end

    // WB stage next state: retire current instruction, then take the accepted one
    always_comb begin
        state_next = state;
        if (wb_free) begin
            if (accept) begin
                state_next = dmemResultSel ? LOAD_WAIT : ALU_WB;
            end else begin
                state_next = IDLE;
            end
        end
    end

    // WB pipeline register, flags and retire strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dmemAdrx   <= '0;
            dmemDataIn <= '0;
            wb_dst     <= '0;
            wb_we      <= 1'b0;
            cFlag      <= 1'b0;
            nFlag      <= 1'b0;
            vFlag      <= 1'b0;
            zFlag      <= 1'b0;
            wbValid    <= 1'b0;
        end else begin
            state   <= state_next;
            wbValid <= rf_we;
            if (accept) begin
                dmemAdrx   <= alu_res;
                dmemDataIn <= reg_b[MEM_W-1:0];
                wb_dst     <= regDest ? rfWrAdrx : rfRdAdrx1;
                wb_we      <= rfWriteEn;
                if (flagWriteEn) begin
                    cFlag <= alu_c;
                    nFlag <= alu_res[WIDTH-1];
                    vFlag <= alu_v;
                    zFlag <= (alu_res == '0);
                end
            end
        end
    end

    // Register file; reset wipes it, so a load interrupted by reset never lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (rf_we) begin
            rf[wb_dst] <= rf_wdata;
        end
    end
endmodule
